elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Floor-request scheduler for the car that sits directly upstream of the floor counter.
- Latches call-button pulses, compares them with the counter's current floor and drives the counter's Up/S controls one floor at a time.
- Sequences door dwell with a SCAN policy: keep the current direction while requests lie ahead, reverse only when none remain ahead.

Parameters:
- NUM_FLOORS, 16: number of floors, 2..16; floors are encoded 0..NUM_FLOORS-1 on a 4-bit bus.
- TRAVEL_CYCLES, 8: dwell cycles before each single-floor step, 1..255.
- DOOR_CYCLES, 16: cycles door_open stays high per stop, 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NUM_FLOORS  call pulses; bit i requests floor i.
- floor  in  4  current floor from the downstream counter (C3..C0).
- Up  out  1  step direction to the counter: 1 = up, 0 = down.
- S  out  1  counter hold: 1 = hold, 0 = step one floor on this edge.
- door_open  out  1  door open at the current floor.
- pending  out  NUM_FLOORS  latched outstanding requests.
- moving  out  1  high in TRAVEL and STEP.
- fault  out  1  sticky: floor input was out of range.

Behaviour:
- Counter contract: the counter moves exactly one floor, in the direction given by Up, on each clk edge that samples S=0. It holds on any edge that samples S=1.
- All outputs are registered or decoded from registered state only. Nothing is combinational from req or floor.
- Reset (reset=0 at a clk edge):
  - state=IDLE; pending=0; dir=1.
  - Up=1; S=1; door_open=0; moving=0; fault=0; timers=0.
  - Reset overrides everything mid-motion. The counter is held because S=1.
- Request latch, each cycle: pending <= (pending | req) & ~clr.
  - clr is the one-hot bit of floor, asserted on the cycle the FSM enters DOOR.
  - A req bit arriving in the same cycle as clr for that floor is dropped.
- Helper signals, from registered pending and floor:
  - above = any pending bit above floor.
  - below = any pending bit below floor.
  - here = pending[floor].
- Up always equals dir.
- States:
  - IDLE: S=1. Transitions, in this priority:
    - here -> DOOR.
    - above -> dir=1, TRAVEL.
    - below -> dir=0, TRAVEL.
    - otherwise stay in IDLE.
  - TRAVEL: S=1, moving=1. Timer counts TRAVEL_CYCLES cycles, then -> STEP.
  - STEP: S=0, moving=1, exactly one cycle, then -> ARRIVE. floor updates at the edge closing STEP.
  - ARRIVE: S=1; evaluates the new floor. Transitions, in this priority:
    - here -> DOOR.
    - requests ahead in dir -> TRAVEL.
    - requests behind -> flip dir, TRAVEL.
    - none -> IDLE.
  - DOOR: S=1, door_open=1 for DOOR_CYCLES cycles.
    - A req for the current floor during DOOR is not latched and reloads the door timer.
    - On expiry, apply the ARRIVE rules without the here check.
- Per-floor traversal takes TRAVEL_CYCLES+2 cycles: TRAVEL, then STEP, then ARRIVE.
- Boundaries:
  - At floor NUM_FLOORS-1, above is 0 by construction, so the FSM never issues an up step. At floor 0 it never issues a down step.
  - A req arriving during STEP for the floor being reached is latched in time for ARRIVE to stop there.
  - Simultaneous above and below in IDLE: up wins.
- Fault: floor >= NUM_FLOORS in any state sets fault and forces state=IDLE with S=1. The FSM issues no moves until reset. pending continues to latch.

Test Plan:
- NUM_FLOORS=8, TRAVEL_CYCLES=2, DOOR_CYCLES=3, behavioural counter model, start at floor 0. Pulse req[3] for 1 cycle -> exactly 3 cycles with S=0, all with Up=1. Each S=0 cycle is 4 cycles apart. door_open is high for exactly 3 cycles at floor 3, pending[3] clears on DOOR entry, then IDLE with S=1.
- At floor 0, pulse req[5]. While the car is in TRAVEL between floors 2 and 3, pulse req[3] -> car stops at 3 (door 3 cycles), then continues to 5 and stops.
- At floor 4 idle, pulse req[1] and req[6] in the same cycle -> car goes up to 6 first, then reverses (dir=0) to 1. Up is never asserted with S=0 at floor 7.
- At floor 2 idle, pulse req[2] -> DOOR with no S=0 cycle. Re-pulse req[2] in door cycle 2 -> door_open is held for 3 more cycles and pending[2] stays 0.
- Drive reset=0 for one edge during STEP on the way up -> next cycle S=1, pending=0, state IDLE, no further counter movement. Drive floor=9 with NUM_FLOORS=8 -> fault=1, S stays 1 until reset.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Elevator floor-request scheduler: latches call pulses, runs a SCAN policy and
// drives the downstream floor counter one floor per STEP cycle.
module elevator_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [3:0]            floor,
  output logic                  Up,
  output logic                  S,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving,
  output logic                  fault
);

  typedef enum logic [2:0] {IDLE, TRAVEL, STEP, ARRIVE, DOOR} state_t;

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_t                state, next_state;
  logic                  dir, next_dir;
  logic [7:0]            timer, next_timer;
  logic [NUM_FLOORS-1:0] floor_hot, clr, door_mask, next_pending;
  logic                  above, below, here, bad_floor, ahead, behind;
  logic                  door_hit, resume;

  always_comb begin
    floor_hot = '0;
    above     = 1'b0;
    below     = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(floor)) floor_hot[i] = 1'b1;
      if (i > int'(floor))  above = above | pending[i];
      if (i < int'(floor))  below = below | pending[i];
    end
    here      = |(pending & floor_hot);
    bad_floor = int'(floor) >= NUM_FLOORS;
    ahead     = dir ? above : below;
    behind    = dir ? below : above;
    door_hit  = |(req & floor_hot);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      dir     <= 1'b1;
      timer   <= '0;
      pending <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= next_state;
      dir     <= next_dir;
      timer   <= next_timer;
      pending <= next_pending;
      fault   <= fault | bad_floor;
    end
  end

  always_comb begin
    next_state = state;
    next_dir   = dir;
    next_timer = timer;
    resume     = 1'b0;
    case (state)
      IDLE: begin
        if (here) begin
          next_state = DOOR;
          next_timer = DOOR_LOAD;
        end else if (above) begin
          next_state = TRAVEL;
          next_dir   = 1'b1;
          next_timer = TRAVEL_LOAD;
        end else if (below) begin
          next_state = TRAVEL;
          next_dir   = 1'b0;
          next_timer = TRAVEL_LOAD;
        end
      end
      TRAVEL: begin
        if (timer == 8'd0) next_state = STEP;
        else               next_timer = timer - 8'd1;
      end
      STEP: next_state = ARRIVE;
      ARRIVE: begin
        if (here) begin
          next_state = DOOR;
          next_timer = DOOR_LOAD;
        end else begin
          resume = 1'b1;
        end
      end
      DOOR: begin
        // A fresh call for this floor keeps the door open instead of re-latching.
        if (door_hit)            next_timer = DOOR_LOAD;
        else if (timer != 8'd0)  next_timer = timer - 8'd1;
        else                     resume = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    if (resume) begin
      if (ahead) begin
        next_state = TRAVEL;
        next_timer = TRAVEL_LOAD;
      end else if (behind) begin
        next_state = TRAVEL;
        next_dir   = ~dir;
        next_timer = TRAVEL_LOAD;
      end else begin
        next_state = IDLE;
        next_timer = '0;
      end
    end

    if (fault || bad_floor) begin
      next_state = IDLE;
      next_dir   = dir;
      next_timer = '0;
    end

    clr          = (next_state == DOOR && state != DOOR) ? floor_hot : '0;
    door_mask    = (state == DOOR) ? floor_hot : '0;
    next_pending = (pending | (req & ~door_mask)) & ~clr;
  end

  always_comb begin
    Up        = dir;
    S         = (state != STEP);
    door_open = (state == DOOR);
    moving    = (state == TRAVEL) || (state == STEP);
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: behavioural floor counter plus a
// countdown-based reference model of the scheduler, directed and random calls.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int TC = 2;
  localparam int DC = 3;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic [NF-1:0] req       = '0;
  logic [3:0]    floor_cnt = 4'd0;
  logic          force_bad = 1'b0;
  logic [3:0]    floor_drv;
  logic          Up, S, door_open, moving, fault;
  logic [NF-1:0] pending;

  int n_vec = 0;
  int n_fail = 0;
  int cycle = 0;

  logic [NF-1:0] m_pend = '0;
  logic          m_dir = 1'b1;
  logic          m_fault = 1'b0;
  int            m_travel = 0;
  int            m_door = 0;
  bit            m_step = 1'b0;
  bit            m_arrive = 1'b0;

  int s0_cnt, s0_up_cnt, door_cyc, gap4_cnt, last_s0;
  int stops[$];

  assign floor_drv = force_bad ? 4'd9 : floor_cnt;

  elevator_ctrl #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .floor(floor_drv),
    .Up(Up),
    .S(S),
    .door_open(door_open),
    .pending(pending),
    .moving(moving),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Downstream counter: one floor per edge that samples S=0.
  always @(posedge clk) begin
    if (S === 1'b0) floor_cnt <= Up ? floor_cnt + 4'd1 : floor_cnt - 4'd1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_vec++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
    end
  endtask

  // Returns 0 rest, 1 open door, 2 go up, 3 go down.
  function automatic int decide(input logic [NF-1:0] p, input int f, input logic d,
                                input bit scan, input bit chk);
    bit ab, be;
    ab = (p >> (f + 1)) != '0;
    be = (p << (NF - f)) != '0;
    if (chk && p[f]) return 1;
    if (scan) begin
      if (d ? ab : be) return d ? 2 : 3;
      if (d ? be : ab) return d ? 3 : 2;
      return 0;
    end
    if (ab) return 2;
    if (be) return 3;
    return 0;
  endfunction

  task automatic model_edge(input logic [NF-1:0] r, input logic rst_n, input int f);
    logic [NF-1:0] old_p, hot;
    int code;
    if (!rst_n) begin
      m_pend = '0; m_dir = 1'b1; m_fault = 1'b0;
      m_travel = 0; m_door = 0; m_step = 1'b0; m_arrive = 1'b0;
      return;
    end
    if (m_fault || f >= NF) begin
      m_fault = 1'b1; m_pend = m_pend | r;
      m_travel = 0; m_door = 0; m_step = 1'b0; m_arrive = 1'b0;
      return;
    end
    old_p = m_pend;
    hot = '0;
    hot[f] = 1'b1;
    code = -1;
    if (m_door > 0) begin
      if ((r & hot) != '0) begin
        m_door = DC;
        m_pend = old_p | (r & ~hot);
        return;
      end
      if (m_door == 1) begin
        m_door = 0;
        code = decide(old_p, f, m_dir, 1'b1, 1'b0);
      end else begin
        m_door--;
      end
    end else if (m_travel > 0) begin
      if (m_travel == 1) m_step = 1'b1;
      m_travel--;
    end else if (m_step) begin
      m_step = 1'b0;
      m_arrive = 1'b1;
    end else if (m_arrive) begin
      m_arrive = 1'b0;
      code = decide(old_p, f, m_dir, 1'b1, 1'b1);
    end else begin
      code = decide(old_p, f, m_dir, 1'b0, 1'b1);
    end
    m_pend = old_p | r;
    case (code)
      1: begin m_door = DC; m_pend = m_pend & ~hot; end
      2: begin m_dir = 1'b1; m_travel = TC; end
      3: begin m_dir = 1'b0; m_travel = TC; end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [NF-1:0] r, input logic rst_n);
    logic prev_door;
    @(negedge clk);
    req = r;
    reset = rst_n;
    prev_door = door_open;
    model_edge(r, rst_n, int'(floor_drv));
    @(posedge clk);
    #1;
    cycle++;
    checkOutput("S", int'(S), int'(!m_step));
    checkOutput("Up", int'(Up), int'(m_dir));
    checkOutput("door_open", int'(door_open), int'(m_door > 0));
    checkOutput("moving", int'(moving), int'(m_travel > 0 || m_step));
    checkOutput("pending", int'(pending), int'(m_pend));
    checkOutput("fault", int'(fault), int'(m_fault));
    if (S === 1'b0) begin
      s0_cnt++;
      if (Up === 1'b1) s0_up_cnt++;
      if (cycle - last_s0 == 4) gap4_cnt++;
      last_s0 = cycle;
      checkOutput("step_range",
                  int'(Up ? (floor_cnt != 4'(NF - 1)) : (floor_cnt != 4'd0)), 1);
    end
    if (door_open === 1'b1) begin
      door_cyc++;
      if (prev_door !== 1'b1) stops.push_back(int'(floor_cnt));
    end
  endtask

  task automatic reset_stats();
    s0_cnt = 0; s0_up_cnt = 0; door_cyc = 0; gap4_cnt = 0; last_s0 = -100;
    stops.delete();
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((m_travel > 0 || m_step || m_arrive || m_door > 0 || m_pend != '0) && n < budget) begin
      applyStimulus('0, 1'b1);
      n++;
    end
    if (n >= budget) checkOutput("settle_timeout", n, 0);
  endtask

  task automatic go_to(input int target);
    logic [NF-1:0] r;
    if (int'(floor_cnt) != target) begin
      r = '0;
      r[target] = 1'b1;
      applyStimulus(r, 1'b1);
      settle(300);
    end
  endtask

  initial begin
    int n;
    logic [NF-1:0] r;
    logic rb;
    reset_stats();

    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("reset_S", int'(S), 1);
    checkOutput("reset_Up", int'(Up), 1);

    // Single call from floor 0 to floor 3.
    reset_stats();
    applyStimulus(8'h08, 1'b1);
    settle(100);
    checkOutput("s1_step_count", s0_cnt, 3);
    checkOutput("s1_step_up", s0_up_cnt, 3);
    checkOutput("s1_step_gap4", gap4_cnt, 2);
    checkOutput("s1_door_cycles", door_cyc, 3);
    checkOutput("s1_floor", int'(floor_cnt), 3);
    checkOutput("s1_S_idle", int'(S), 1);

    // Intermediate call picked up on the way.
    go_to(0);
    reset_stats();
    applyStimulus(8'h20, 1'b1);
    n = 0;
    while (!(m_travel > 0 && floor_cnt == 4'd2) && n < 100) begin
      applyStimulus('0, 1'b1);
      n++;
    end
    checkOutput("s2_reach_timeout", int'(n < 100), 1);
    applyStimulus(8'h08, 1'b1);
    settle(200);
    checkOutput("s2_stop_count", stops.size(), 2);
    checkOutput("s2_stop0", (stops.size() > 0) ? stops[0] : -1, 3);
    checkOutput("s2_stop1", (stops.size() > 1) ? stops[1] : -1, 5);

    // Calls on both sides: up first, then reverse.
    go_to(4);
    reset_stats();
    applyStimulus(8'h42, 1'b1);
    settle(300);
    checkOutput("s3_stop_count", stops.size(), 2);
    checkOutput("s3_stop0", (stops.size() > 0) ? stops[0] : -1, 6);
    checkOutput("s3_stop1", (stops.size() > 1) ? stops[1] : -1, 1);

    // Call at the current floor, re-pulsed during the dwell.
    go_to(2);
    reset_stats();
    applyStimulus(8'h04, 1'b1);
    n = 0;
    while (m_door == 0 && n < 20) begin
      applyStimulus('0, 1'b1);
      n++;
    end
    checkOutput("s4_door_timeout", int'(n < 20), 1);
    applyStimulus('0, 1'b1);
    applyStimulus(8'h04, 1'b1);
    checkOutput("s4_pending2", int'(pending[2]), 0);
    settle(50);
    checkOutput("s4_door_cycles", door_cyc, 5);
    checkOutput("s4_no_step", s0_cnt, 0);

    // Reset asserted during an upward STEP.
    applyStimulus(8'h40, 1'b1);
    n = 0;
    while (!m_step && n < 20) begin
      applyStimulus('0, 1'b1);
      n++;
    end
    checkOutput("s5_step_timeout", int'(n < 20), 1);
    applyStimulus('0, 1'b0);
    reset_stats();
    for (int i = 0; i < 10; i++) applyStimulus('0, 1'b1);
    checkOutput("s5_floor_held", int'(floor_cnt), 3);
    checkOutput("s5_no_step", s0_cnt, 0);
    checkOutput("s5_pending", int'(pending), 0);

    // Out-of-range floor is sticky until reset.
    reset_stats();
    force_bad = 1'b1;
    applyStimulus(8'h10, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1);
    checkOutput("s6_fault", int'(fault), 1);
    force_bad = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus('0, 1'b1);
    checkOutput("s6_fault_sticky", int'(fault), 1);
    checkOutput("s6_pending_latched", int'(pending), 32'h10);
    checkOutput("s6_no_step", s0_cnt, 0);
    checkOutput("s6_floor_held", int'(floor_cnt), 3);
    applyStimulus('0, 1'b0);
    checkOutput("s6_fault_cleared", int'(fault), 0);

    // Random call traffic with rare resets.
    for (int i = 0; i < 800; i++) begin
      r = '0;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
      rb = ($urandom_range(0, 299) != 0);
      applyStimulus(r, rb);
    end
    settle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
